ccff_chain_loader: RTL and testbench

Configuration-chain loader sitting directly upstream of the I/O and logic tiles' `ccff_head` inputs. It accepts bitstream words from a host over a valid/ready interface and serializes them LSB-first into the tile configuration flip-flop chain. It drives the chain through a gated programming clock and captures the bits emerging from the chain's `ccff_tail` as readback words, so the host can verify the previous chain contents.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_chain_loader_if.sv | 16 +
 rtl/ccff_clk_gate.sv | 13 +
 rtl/sky130_fd_sc_hd__dlclkp.sv | 15 +
 rtl/ccff_chain_loader.sv | 137 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 180 ++++++++++++++++++
 6 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// Pure declarations: no latency, no flow control.
package ccff_loader_pkg;

  localparam int CCFF_CHAIN_LEN_DEF = 1024;
  localparam int CCFF_WORD_W_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } ccff_ld_state_t;

  function automatic int unsigned ccff_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host bitstream word handshake (valid/ready) plus the readback word pulse.
// Readback has no backpressure: the host must take rb_data whenever rb_valid is high.
interface ccff_chain_loader_if
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W_DEF
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (output cfg_data, cfg_valid, input cfg_ready, rb_data, rb_valid);
  modport slave  (input cfg_data, cfg_valid, output cfg_ready, rb_data, rb_valid);
endinterface

// File: rtl/ccff_clk_gate.sv
// Gated programming clock for the configuration chain; a pulse appears on each
// prog_clk rising edge that follows a cycle with en_q high. No flow control.
module ccff_clk_gate (
  input  logic prog_clk,
  input  logic en_q,
  output logic ccff_prog_clk
);
  sky130_fd_sc_hd__dlclkp u_icg (
    .CLK  (prog_clk),
    .GATE (en_q),
    .GCLK (ccff_prog_clk)
  );
endmodule

// File: rtl/sky130_fd_sc_hd__dlclkp.sv
// Behavioural model of the latch-based clock-gating cell; the enable is captured while CLK is low.
// Combinational output, so GCLK follows CLK in the same delta as the root edge.
module sky130_fd_sc_hd__dlclkp (
  input  logic CLK,
  input  logic GATE,
  output logic GCLK
);
  logic gate_l;

  always_latch begin
    if (!CLK) gate_l <= GATE;
  end

  assign GCLK = CLK & gate_l;
endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host words LSB-first into the ccff chain and packs the bits leaving ccff_tail into readback words.
// Word accepted at edge A reaches the chain at A+2..A+n+1; host stalls simply freeze the gated clock.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter int WORD_W    = CCFF_WORD_W_DEF,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                start,
  input  logic                ccff_tail,
  output logic                ccff_head,
  output logic                ccff_prog_clk,
  output logic                busy,
  output logic                done,
  ccff_chain_loader_if.slave  cfg
);
  localparam int NB_W = $clog2(WORD_W + 1);

  ccff_ld_state_t    state;
  logic [WORD_W-1:0] shreg;
  logic [NB_W-1:0]   nbits;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  rb_cnt;
  logic [WORD_W-1:0] pk_data;
  logic [NB_W-1:0]   pk_idx;
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_valid_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              head_q;
  logic              en_q;

  logic [CNT_W-1:0]  rem;
  logic [WORD_W-1:0] pk_next;

  assign rem     = CNT_W'(CHAIN_LEN) - count;
  assign pk_next = pk_data | (WORD_W'(ccff_tail) << pk_idx);

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      nbits      <= '0;
      count      <= '0;
      rb_cnt     <= '0;
      pk_data    <= '0;
      pk_idx     <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;

      // en_q high means this edge is a chain shift edge: ccff_tail still holds the pre-edge bit.
      if (en_q) begin
        rb_cnt <= rb_cnt + 1'b1;
        if (pk_idx == NB_W'(WORD_W - 1) || 32'(rb_cnt) == CHAIN_LEN - 1) begin
          rb_data_q  <= pk_next;
          rb_valid_q <= 1'b1;
          pk_data    <= '0;
          pk_idx     <= '0;
        end else begin
          pk_data <= pk_next;
          pk_idx  <= pk_idx + 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_FETCH;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            count   <= '0;
            rb_cnt  <= '0;
            pk_data <= '0;
            pk_idx  <= '0;
          end
        end
        ST_FETCH: begin
          en_q <= 1'b0;
          if (cfg.cfg_valid) begin
            shreg   <= cfg.cfg_data;
            nbits   <= NB_W'(ccff_min(WORD_W, 32'(rem)));
            ready_q <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          head_q <= shreg[0];
          en_q   <= 1'b1;
          shreg  <= shreg >> 1;
          count  <= count + 1'b1;
          nbits  <= nbits - 1'b1;
          // Bits of a partial final word beyond nbits are never shifted out.
          if (nbits == NB_W'(1)) begin
            if (32'(count) + 1 < CHAIN_LEN) begin
              state   <= ST_FETCH;
              ready_q <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          en_q   <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ccff_clk_gate u_clk_gate (
    .prog_clk      (prog_clk),
    .en_q          (en_q),
    .ccff_prog_clk (ccff_prog_clk)
  );

  assign ccff_head     = head_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.rb_data   = rb_data_q;
  assign cfg.rb_valid  = rb_valid_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: two loaders (16-bit and 12-bit chains) with behavioural chains; readback checked by a scoreboard.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic head_a, head_b, pclk_a, pclk_b;
  logic busy_a, busy_b, done_a, done_b;
  logic tail_a = 1'b0, tail_b = 1'b0;
  logic head_sa = 1'b0, head_sb = 1'b0;
  logic [15:0] chain_a, pre_a;
  logic [11:0] chain_b, pre_b;
  logic load_a = 1'b0, load_b = 1'b0;
  int pulses_a = 0, pulses_b = 0;
  int checks = 0, errors = 0;
  int ecnt;
  logic [15:0] exp_a, exp_b;
  logic [7:0] qa[$], qb[$];

  always #5 clk = ~clk;

  ccff_chain_loader_if #(.WORD_W(8)) ifa ();
  ccff_chain_loader_if #(.WORD_W(8)) ifb ();

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start_a), .ccff_tail(tail_a),
    .ccff_head(head_a), .ccff_prog_clk(pclk_a), .busy(busy_a), .done(done_a), .cfg(ifa)
  );
  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start_b), .ccff_tail(tail_b),
    .ccff_head(head_b), .ccff_prog_clk(pclk_b), .busy(busy_b), .done(done_b), .cfg(ifb)
  );

  // Chain models: head sampled mid-cycle, tail updated mid-cycle, so neither races the root edge.
  always @(negedge clk) begin
    head_sa <= head_a; tail_a <= chain_a[0];
    head_sb <= head_b; tail_b <= chain_b[0];
  end
  always @(posedge pclk_a or posedge load_a)
    if (load_a) chain_a <= pre_a; else chain_a <= {head_sa, chain_a[15:1]};
  always @(posedge pclk_b or posedge load_b)
    if (load_b) chain_b <= pre_b; else chain_b <= {head_sb, chain_b[11:1]};
  always @(posedge pclk_a) pulses_a <= pulses_a + 1;
  always @(posedge pclk_b) pulses_b <= pulses_b + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; ecnt++;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_cfg(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin ifb.cfg_data = d; ifb.cfg_valid = v; end
    else     begin ifa.cfg_data = d; ifa.cfg_valid = v; end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ifb.cfg_ready : ifa.cfg_ready;
  endfunction

  task automatic preload(input bit sel, input logic [15:0] val);
    if (sel) begin pre_b = val[11:0]; exp_b = val; load_b = 1'b1; #1 load_b = 1'b0; end
    else     begin pre_a = val;       exp_a = val; load_a = 1'b1; #1 load_a = 1'b0; end
  endtask

  task automatic wait_ready(input bit sel);
    int t = 0;
    while (!rdy(sel) && t < 100) begin tick(); t++; end
    chk("ready_timeout", 32'(t < 100), 1);
  endtask

  task automatic do_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1, input int gap,
                         input bit poke, input int exp_edge, input logic [15:0] exp_chain);
    int p0, pg, t;
    if (sel) begin qb.push_back(exp_b[7:0]); qb.push_back({4'h0, exp_b[11:8]}); end
    else     begin qa.push_back(exp_a[7:0]); qa.push_back(exp_a[15:8]); end
    p0 = sel ? pulses_b : pulses_a;
    ecnt = -1;
    set_start(sel, 1'b1); tick(); set_start(sel, 1'b0);
    set_cfg(sel, w0, 1'b1);
    wait_ready(sel); tick();
    set_cfg(sel, w1, logic'(gap == 0));
    if (poke) set_start(sel, 1'b1);
    tick(); set_start(sel, 1'b0);
    if (poke) chk("busy_after_poke", sel ? busy_b : busy_a, 1);
    wait_ready(sel);
    if (gap > 0) begin
      tick();
      pg = sel ? pulses_b : pulses_a;
      repeat (gap - 1) tick();
      chk("gap_pulses", 32'((sel ? pulses_b : pulses_a) - pg), 0);
      set_cfg(sel, w1, 1'b1);
    end
    tick(); set_cfg(sel, w1, 1'b0);
    t = 0;
    while (!(sel ? done_b : done_a) && t < 100) begin tick(); t++; end
    chk("done_timeout", 32'(sel ? done_b : done_a), 1);
    if (exp_edge >= 0) chk("done_edge", 32'(ecnt), 32'(exp_edge));
    tick(); tick();
    chk("chain", sel ? {4'h0, chain_b} : chain_a, exp_chain);
    chk("pulses", 32'((sel ? pulses_b : pulses_a) - p0), sel ? 12 : 16);
    chk("busy_done", sel ? {busy_b, done_b} : {busy_a, done_a}, 2'b01);
    if (sel) exp_b = exp_chain; else exp_a = exp_chain;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    set_cfg(0, 8'h00, 1'b0); set_cfg(1, 8'h00, 1'b0);
    fork
      forever begin
        @(negedge clk);
        if (ifa.rb_valid) begin
          if (qa.size() == 0) chk("rb_a_unexpected", 1, 0);
          else chk("rb_a", ifa.rb_data, qa.pop_front());
        end
        if (ifb.rb_valid) begin
          if (qb.size() == 0) chk("rb_b_unexpected", 1, 0);
          else chk("rb_b", ifb.rb_data, qb.pop_front());
        end
      end
    join_none

    repeat (2) @(posedge clk); #1;
    chk("reset_outs_a", {ifa.cfg_ready, head_a, ifa.rb_valid, busy_a, done_a, pclk_a}, 0);
    chk("reset_rb_a", ifa.rb_data, 0);
    chk("reset_outs_b", {ifb.cfg_ready, head_b, ifb.rb_valid, busy_b, done_b, pclk_b}, 0);
    #5 rst_n = 1'b1;
    tick();

    preload(0, 16'hBEEF);
    preload(1, 16'h0ABC);
    do_load(0, 8'h5A, 8'hC3, 0, 0, 19, 16'hC35A);
    do_load(1, 8'hFF, 8'hA5, 0, 0, 15, 16'h05FF);
    do_load(0, 8'h5A, 8'hC3, 5, 0, -1, 16'hC35A);
    do_load(0, 8'h11, 8'h22, 0, 1, 19, 16'h2211);

    // Reset while the first word is mid-shift.
    set_start(0, 1'b1); tick(); set_start(0, 1'b0);
    set_cfg(0, 8'h99, 1'b1);
    wait_ready(0); tick();
    set_cfg(0, 8'h00, 1'b0);
    repeat (3) tick();
    chk("busy_mid_shift", busy_a, 1);
    #5 rst_n = 1'b0;
    #1;
    chk("rst_outs_a", {ifa.cfg_ready, head_a, ifa.rb_valid, busy_a, done_a, pclk_a}, 0);
    p = pulses_a;
    repeat (3) tick();
    #5 rst_n = 1'b1;
    repeat (2) tick();
    chk("rst_no_pulses", 32'(pulses_a - p), 0);
    chk("rst_idle", {ifa.cfg_ready, busy_a, done_a}, 0);

    preload(0, 16'h0F0F);
    do_load(0, 8'h34, 8'h12, 0, 0, 19, 16'h1234);
    do_load(0, 8'hCD, 8'hAB, 0, 0, 19, 16'hABCD);

    repeat (3) tick();
    chk("rb_a_left", 32'(qa.size()), 0);
    chk("rb_b_left", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
